thread_fetch: RTL and testbench

THREAD_FETCH -- requirements
Module: thread_fetch

---
 rtl/thread_fetch.sv | 88 ++++++++
 tb/tb_thread_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch.sv
// Two-thread round-robin instruction fetch with a single output register,
// per-thread redirect/halt, and squash of a held instruction whose thread is redirected or halted.
module thread_fetch #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC0_INIT = '0,
    parameter logic [WIDTH-1:0] PC1_INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic             instr_tid,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             redir_valid,
    input  logic             redir_tid,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic             halt_valid,
    input  logic             halt_tid,
    output logic             halted
);

    logic [1:0][WIDTH-1:0] pc;
    logic [1:0]            run;
    logic                  valid_q;
    logic                  last_tid;

    logic [1:0] redir_hit, halt_hit, elig, run_next;
    logic       squash, slot_free, has_sel, sel, fetch;

    always_comb begin
        redir_hit = '0;
        halt_hit  = '0;
        if (redir_valid) redir_hit[redir_tid] = 1'b1;
        if (halt_valid)  halt_hit[halt_tid]   = 1'b1;
        // A thread being redirected or halted this cycle sits out one fetch slot
        elig      = run & ~redir_hit & ~halt_hit;
        run_next  = run & ~halt_hit;

        squash      = valid_q & (redir_hit[instr_tid] | halt_hit[instr_tid]);
        instr_valid = valid_q & ~squash;
        // A squashed entry is dead, so its slot can be refilled at the same edge
        slot_free   = ~valid_q | squash | instr_ready;

        has_sel = |elig;
        sel     = elig[~last_tid] ? ~last_tid : last_tid;
        fetch   = slot_free & has_sel;

        imem_addr = has_sel ? pc[sel] : pc[last_tid];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc[0]     <= PC0_INIT;
            pc[1]     <= PC1_INIT;
            run       <= 2'b11;
            valid_q   <= 1'b0;
            instr     <= '0;
            instr_tid <= 1'b0;
            instr_pc  <= '0;
            last_tid  <= 1'b1;
            halted    <= 1'b0;
        end else begin
            run    <= run_next;
            halted <= ~|run_next;

            // Halt beats redirect, and a halted thread ignores redirects
            for (int t = 0; t < 2; t++) begin
                if (redir_hit[t] && run[t] && !halt_hit[t])
                    pc[t] <= redir_pc;
            end

            if (fetch) begin
                valid_q   <= 1'b1;
                instr     <= imem_rdata;
                instr_tid <= sel;
                instr_pc  <= pc[sel];
                pc[sel]   <= pc[sel] + WIDTH'(2);
                last_tid  <= sel;
            end else if (slot_free) begin
                valid_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thread_fetch.sv
// Bench for thread_fetch: directed vector table, hand sequences for wrap/reset,
// then random traffic against a cycle-level reference model.
module tb_thread_fetch;

    localparam logic [15:0] SCRAMBLE = 16'hA5C3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [15:0] instr, instr_pc;
    logic        instr_tid;
    logic        redir_valid, redir_tid, halt_valid, halt_tid, halted;
    logic [15:0] redir_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ SCRAMBLE;

    thread_fetch dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_tid(instr_tid), .instr_pc(instr_pc),
        .redir_valid(redir_valid), .redir_tid(redir_tid), .redir_pc(redir_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic rt, input logic [15:0] rp,
                         input logic hv, input logic ht, input logic rdy);
        redir_valid = rv; redir_tid = rt; redir_pc = rp;
        halt_valid  = hv; halt_tid  = ht; instr_ready = rdy;
    endtask

    // Leaves the bench at posedge+1 with reset just released (cycle 0).
    task automatic do_reset();
        drive(0, 0, 16'h0, 0, 0, 1);
        reset = 1'b0;
        #1 chk("rst_async_valid", instr_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halted", halted, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr_tid", instr_tid, 0);
        chk("rst_instr", instr, 0);
        reset = 1'b1;
        #1 chk("rst_imem_addr_t0", imem_addr, 16'h0000);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_pc [2];
    logic        m_run [2];
    logic        m_vq, m_tid, m_last, m_halted;
    logic [15:0] m_instr, m_ipc;

    function automatic void m_reset();
        m_pc[0] = 16'h0000; m_pc[1] = 16'h0001;
        m_run[0] = 1; m_run[1] = 1;
        m_vq = 0; m_tid = 0; m_last = 1; m_halted = 0;
        m_instr = 0; m_ipc = 0;
    endfunction

    function automatic logic m_targeted(input logic t);
        return (redir_valid && redir_tid == t) || (halt_valid && halt_tid == t);
    endfunction

    // Called at negedge with inputs stable: check outputs, then advance to the next edge.
    task automatic m_cycle();
        logic kill, ev, open, found, s;
        logic [15:0] new_pc [2];
        logic        new_run [2];
        kill = m_vq && m_targeted(m_tid);
        ev   = m_vq && !kill;
        chk("rnd_valid", instr_valid, ev);
        chk("rnd_halted", halted, m_halted);
        if (ev) begin
            chk("rnd_tid", instr_tid, m_tid);
            chk("rnd_pc", instr_pc, m_ipc);
            chk("rnd_instr", instr, m_instr);
        end
        open  = !m_vq || kill || instr_ready;
        found = 0; s = 0;
        foreach (m_run[k]) begin
            logic t;
            t = (k == 0) ? !m_last : m_last;
            if (!found && m_run[t] && !m_targeted(t)) begin
                found = 1; s = t;
            end
        end
        if (open && found) chk("rnd_imem_addr", imem_addr, m_pc[s]);

        for (int t = 0; t < 2; t++) begin
            new_pc[t]  = m_pc[t];
            new_run[t] = m_run[t] && !(halt_valid && halt_tid == t);
            if (redir_valid && redir_tid == t && m_run[t] && new_run[t]) new_pc[t] = redir_pc;
        end
        if (open && found) begin
            m_vq = 1; m_tid = s; m_ipc = m_pc[s];
            m_instr = m_pc[s] ^ SCRAMBLE;
            new_pc[s] = m_pc[s] + 16'd2;
            m_last = s;
        end else if (open) begin
            m_vq = 0;
        end
        m_pc = new_pc;
        m_run = new_run;
        m_halted = !new_run[0] && !new_run[1];
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic rv; logic rt; logic [15:0] rp;
        logic hv; logic ht; logic rdy;
        logic ev; logic et; logic [15:0] ep; logic eh;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic rt, input logic [15:0] rp,
                                input logic hv, input logic ht, input logic rdy,
                                input logic ev, input logic et, input logic [15:0] ep,
                                input logic eh);
        vec_t v;
        v.rv = rv; v.rt = rt; v.rp = rp; v.hv = hv; v.ht = ht; v.rdy = rdy;
        v.ev = ev; v.et = et; v.ep = ep; v.eh = eh;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        drive(0, 0, 16'h0, 0, 0, 1);

        //             rv rt rp       hv ht rdy  ev et ep       eh
        tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 1,   1, 0, 16'h0000, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 1,   1, 1, 16'h0001, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0002, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0002, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0002, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 1,   1, 0, 16'h0002, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 1,   1, 1, 16'h0003, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 1,   1, 0, 16'h0004, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 0,   1, 1, 16'h0005, 0);
        tbl[10] = mk(1, 1, 16'h0040, 0, 0, 0,   0, 0, 16'h0000, 0);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 1,   1, 0, 16'h0006, 0);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 1,   1, 1, 16'h0040, 0);
        tbl[13] = mk(0, 0, 16'h0000, 1, 0, 1,   0, 0, 16'h0000, 0);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 1,   1, 1, 16'h0042, 0);
        tbl[15] = mk(0, 0, 16'h0000, 0, 0, 1,   1, 1, 16'h0044, 0);
        tbl[16] = mk(1, 0, 16'h0100, 0, 0, 1,   1, 1, 16'h0046, 0);
        tbl[17] = mk(1, 1, 16'h0200, 1, 1, 1,   0, 0, 16'h0000, 0);
        tbl[18] = mk(0, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h0000, 1);
        tbl[19] = mk(0, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h0000, 1);

        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rv, tbl[i].rt, tbl[i].rp, tbl[i].hv, tbl[i].ht, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].eh);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_tid", i), instr_tid, tbl[i].et);
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].ep);
                chk($sformatf("tbl%0d_instr", i), instr, tbl[i].ep ^ SCRAMBLE);
            end
            @(posedge clk); #1;
        end

        // PC wrap on thread 0, then reset while an instruction is held
        do_reset();
        drive(1, 0, 16'hFFFE, 0, 0, 1);
        @(negedge clk); chk("wrap_c0_valid", instr_valid, 0);
        @(posedge clk); #1 drive(0, 0, 16'h0, 0, 0, 1);
        @(negedge clk); chk("wrap_c1_pc", instr_pc, 16'h0001); chk("wrap_c1_tid", instr_tid, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("wrap_c2_pc", instr_pc, 16'hFFFE); chk("wrap_c2_tid", instr_tid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("wrap_c3_pc", instr_pc, 16'h0003);
        @(posedge clk); #1;
        @(negedge clk); chk("wrap_c4_pc", instr_pc, 16'h0000); chk("wrap_c4_valid", instr_valid, 1);
        reset = 1'b0;
        #1 chk("midreset_valid", instr_valid, 0);
        chk("midreset_pc", instr_pc, 0);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk); chk("post_rst_c0_valid", instr_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("post_rst_c1_pc", instr_pc, 16'h0000); chk("post_rst_c1_tid", instr_tid, 0);
        @(posedge clk); #1;

        // Random traffic against the model, with periodic resets to revive halted threads
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                do_reset();
                m_reset();
            end
            begin
                logic [15:0] rp;
                case ($urandom_range(3))
                    0: rp = 16'hFFFE;
                    1: rp = 16'hFFFF;
                    default: rp = 16'($urandom);
                endcase
                drive($urandom_range(7) == 0, 1'($urandom), rp,
                      $urandom_range(63) == 0, 1'($urandom), $urandom_range(3) != 0);
            end
            @(negedge clk);
            m_cycle();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
